// File: rtl/bus_transfer_sequencer_if.sv
// rtl/bus_transfer_sequencer_if.sv - request handshake and bus enable bundle for bus_transfer_sequencer
interface bus_transfer_sequencer_if #(
  parameter int NUM_SRC = 8,
  parameter int NUM_DST = 8,
  parameter int SRC_W   = 3,
  parameter int DST_W   = 3
);
  logic               req_valid;
  logic               req_ready;
  logic [SRC_W-1:0]   req_src;
  logic [DST_W-1:0]   req_dst;
  logic [NUM_SRC-1:0] drive_en;
  logic [NUM_DST-1:0] load_en;
  logic               done;
  logic               err;
  logic               busy;

  modport master (
    output req_valid, req_src, req_dst,
    input  req_ready, drive_en, load_en, done, err, busy
  );

  modport slave (
    input  req_valid, req_src, req_dst,
    output req_ready, drive_en, load_en, done, err, busy
  );
endinterface

// File: rtl/bus_transfer_sequencer.sv
// rtl/bus_transfer_sequencer.sv - drive/load/turnaround sequencer for the shared 16-bit data bus
module bus_transfer_sequencer #(
  parameter int NUM_SRC    = 8,
  parameter int NUM_DST    = 8,
  parameter int SRC_W      = 3,
  parameter int DST_W      = 3,
  parameter int TURNAROUND = 1
) (
  input  logic clk,
  input  logic rst_n,
  bus_transfer_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, DRIVE, LOAD, TURN} state_t;

  state_t             state_q, state_d;
  logic [SRC_W-1:0]   cur_src_q, cur_src_d;
  logic [DST_W-1:0]   cur_dst_q, cur_dst_d;
  logic [1:0]         turn_q, turn_d;
  logic [SRC_W-1:0]   q_src [2];
  logic [DST_W-1:0]   q_dst [2];
  logic               rd_ptr_q, wr_ptr_q;
  logic [1:0]         count_q, count_d;
  logic               push, pop, dispatch, head_ok;
  logic [NUM_SRC-1:0] drive_q, drive_d;
  logic [NUM_DST-1:0] load_q, load_d;
  logic               done_q, err_q, err_d, busy_q;

  assign bus.req_ready = (count_q != 2'd2);
  assign push          = bus.req_valid && (count_q != 2'd2);
  assign head_ok       = (32'(q_src[rd_ptr_q]) < NUM_SRC) && (32'(q_dst[rd_ptr_q]) < NUM_DST);
  assign count_d       = count_q + {1'b0, push} - {1'b0, pop};

  always_comb begin
    state_d   = state_q;
    cur_src_d = cur_src_q;
    cur_dst_d = cur_dst_q;
    turn_d    = turn_q;
    dispatch  = 1'b0;
    pop       = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      IDLE:  dispatch = 1'b1;
      DRIVE: state_d = LOAD;
      LOAD: begin
        if (TURNAROUND > 0) begin
          state_d = TURN;
          turn_d  = 2'(TURNAROUND - 1);
        end else begin
          dispatch = 1'b1;
        end
      end
      TURN: begin
        if (turn_q == 2'd0) dispatch = 1'b1;
        else                turn_d   = turn_q - 2'd1;
      end
      default: state_d = IDLE;
    endcase
    // An invalid head is consumed here and leaves the FSM idle for one cycle
    if (dispatch) begin
      state_d = IDLE;
      if (count_q != 2'd0) begin
        pop = 1'b1;
        if (head_ok) begin
          state_d   = DRIVE;
          cur_src_d = q_src[rd_ptr_q];
          cur_dst_d = q_dst[rd_ptr_q];
        end else begin
          err_d = 1'b1;
        end
      end
    end
  end

  always_comb begin
    drive_d = '0;
    load_d  = '0;
    for (int i = 0; i < NUM_SRC; i++)
      drive_d[i] = (state_d == DRIVE || state_d == LOAD) && (32'(cur_src_d) == i);
    for (int i = 0; i < NUM_DST; i++)
      load_d[i] = (state_d == LOAD) && (32'(cur_dst_d) == i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cur_src_q <= '0;
      cur_dst_q <= '0;
      turn_q    <= '0;
      q_src[0]  <= '0;
      q_src[1]  <= '0;
      q_dst[0]  <= '0;
      q_dst[1]  <= '0;
      rd_ptr_q  <= 1'b0;
      wr_ptr_q  <= 1'b0;
      count_q   <= '0;
      drive_q   <= '0;
      load_q    <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_src_q <= cur_src_d;
      cur_dst_q <= cur_dst_d;
      turn_q    <= turn_d;
      if (push) begin
        q_src[wr_ptr_q] <= bus.req_src;
        q_dst[wr_ptr_q] <= bus.req_dst;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_d;
      drive_q <= drive_d;
      load_q  <= load_d;
      done_q  <= (state_d == LOAD);
      err_q   <= err_d;
      busy_q  <= (state_d != IDLE) || (count_d != 2'd0);
    end
  end

  assign bus.drive_en = drive_q;
  assign bus.load_en  = load_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.busy     = busy_q;
endmodule

// File: tb/tb_bus_transfer_sequencer.sv
// tb/tb_bus_transfer_sequencer.sv - directed and random checks of bus_transfer_sequencer against a slot schedule model
module tb_bus_transfer_sequencer;
  localparam int NDST = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic [2:0] req_src = 3'd0;
  logic [2:0] req_dst = 3'd0;

  always #5 clk = ~clk;

  bus_transfer_sequencer_if #(.NUM_SRC(8), .NUM_DST(8), .SRC_W(3), .DST_W(3)) ifa ();
  bus_transfer_sequencer_if #(.NUM_SRC(8), .NUM_DST(8), .SRC_W(3), .DST_W(3)) ifb ();
  bus_transfer_sequencer_if #(.NUM_SRC(6), .NUM_DST(8), .SRC_W(3), .DST_W(3)) ifc ();

  bus_transfer_sequencer #(.NUM_SRC(8), .NUM_DST(8), .SRC_W(3), .DST_W(3), .TURNAROUND(1))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  bus_transfer_sequencer #(.NUM_SRC(8), .NUM_DST(8), .SRC_W(3), .DST_W(3), .TURNAROUND(0))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
  bus_transfer_sequencer #(.NUM_SRC(6), .NUM_DST(8), .SRC_W(3), .DST_W(3), .TURNAROUND(2))
    dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc));

  assign ifa.req_valid = req_valid;
  assign ifa.req_src   = req_src;
  assign ifa.req_dst   = req_dst;
  assign ifb.req_valid = req_valid;
  assign ifb.req_src   = req_src;
  assign ifb.req_dst   = req_dst;
  assign ifc.req_valid = req_valid;
  assign ifc.req_src   = req_src;
  assign ifc.req_dst   = req_dst;

  logic [7:0] o_drive [3];
  logic [7:0] o_load  [3];
  logic       o_done  [3];
  logic       o_err   [3];
  logic       o_busy  [3];
  logic       o_ready [3];

  assign o_drive[0] = ifa.drive_en;
  assign o_drive[1] = ifb.drive_en;
  assign o_drive[2] = {2'b00, ifc.drive_en};
  assign o_load[0]  = ifa.load_en;
  assign o_load[1]  = ifb.load_en;
  assign o_load[2]  = ifc.load_en;
  assign o_done[0]  = ifa.done;
  assign o_done[1]  = ifb.done;
  assign o_done[2]  = ifc.done;
  assign o_err[0]   = ifa.err;
  assign o_err[1]   = ifb.err;
  assign o_err[2]   = ifc.err;
  assign o_busy[0]  = ifa.busy;
  assign o_busy[1]  = ifb.busy;
  assign o_busy[2]  = ifc.busy;
  assign o_ready[0] = ifa.req_ready;
  assign o_ready[1] = ifb.req_ready;
  assign o_ready[2] = ifc.req_ready;

  // Model: each valid transfer owns a slot of 2+TURNAROUND cycles; left counts the cycles remaining
  int   left [3];
  int   cs   [3];
  int   cd   [3];
  logic merr [3];
  int   q0[$], q1[$], q2[$];
  int   checks = 0, errors = 0, cyc = 0;
  int   done_cnt [3];
  int   err_cnt  [3];
  int   done_a[$], done_b[$];
  int   k, guard;
  logic saw_not_ready;

  function automatic int ta_of(input int i);
    case (i)
      0: return 1;
      1: return 0;
      default: return 2;
    endcase
  endfunction

  function automatic int nsrc_of(input int i);
    return (i == 2) ? 6 : 8;
  endfunction

  function automatic int qsize(input int i);
    case (i)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) begin
      left[i] = 0;
      cs[i]   = 0;
      cd[i]   = 0;
      merr[i] = 1'b0;
    end
    q0.delete();
    q1.delete();
    q2.delete();
  endfunction

  function automatic void model_edge(input int i, input logic v, input int s, input int d);
    int lq[$];
    int e;
    bit rdy;
    case (i)
      0: lq = q0;
      1: lq = q1;
      default: lq = q2;
    endcase
    rdy = lq.size() < 2;
    merr[i] = 1'b0;
    if (left[i] > 1) begin
      left[i]--;
    end else begin
      left[i] = 0;
      if (lq.size() > 0) begin
        e = lq.pop_front();
        if ((e / 8) < nsrc_of(i) && (e % 8) < NDST) begin
          left[i] = 2 + ta_of(i);
          cs[i]   = e / 8;
          cd[i]   = e % 8;
        end else begin
          merr[i] = 1'b1;
        end
      end
    end
    if (v && rdy) lq.push_back(s * 8 + d);
    case (i)
      0: q0 = lq;
      1: q1 = lq;
      default: q2 = lq;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      int         age;
      logic       act;
      logic [7:0] ed, el;
      act = left[i] > 0;
      age = 2 + ta_of(i) - left[i];
      ed  = (act && age <= 1) ? (8'd1 << cs[i]) : 8'd0;
      el  = (act && age == 1) ? (8'd1 << cd[i]) : 8'd0;
      chk($sformatf("drive_en[%0d]@%0d", i, cyc), 32'(o_drive[i]), 32'(ed));
      chk($sformatf("load_en[%0d]@%0d", i, cyc), 32'(o_load[i]), 32'(el));
      chk($sformatf("done[%0d]@%0d", i, cyc), 32'(o_done[i]), 32'(act && age == 1));
      chk($sformatf("err[%0d]@%0d", i, cyc), 32'(o_err[i]), 32'(merr[i]));
      chk($sformatf("busy[%0d]@%0d", i, cyc), 32'(o_busy[i]), 32'(act || qsize(i) > 0));
      chk($sformatf("req_ready[%0d]@%0d", i, cyc), 32'(o_ready[i]), 32'(qsize(i) < 2));
      chk($sformatf("drive_onehot[%0d]@%0d", i, cyc), 32'($countones(o_drive[i]) <= 1), 32'd1);
      chk($sformatf("load_has_drive[%0d]@%0d", i, cyc),
          32'((o_load[i] == 8'd0) || (o_drive[i] != 8'd0)), 32'd1);
      if (o_done[i] === 1'b1) done_cnt[i]++;
      if (o_err[i] === 1'b1) err_cnt[i]++;
    end
    if (o_done[0] === 1'b1) done_a.push_back(cyc);
    if (o_done[1] === 1'b1) done_b.push_back(cyc);
  endtask

  task automatic step(input logic v, input logic [2:0] s, input logic [2:0] d);
    req_valid = v;
    req_src   = s;
    req_dst   = d;
    @(posedge clk);
    for (int i = 0; i < 3; i++) model_edge(i, v, int'(s), int'(d));
    cyc++;
    @(negedge clk);
    check_all();
  endtask

  initial begin
    model_reset();
    for (int i = 0; i < 3; i++) begin
      done_cnt[i] = 0;
      err_cnt[i]  = 0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all();
    rst_n = 1'b1;

    // single transfer 3 -> 5 on the TURNAROUND=1 instance
    step(1'b1, 3'd3, 3'd5);
    chk("single_e0_drive", 32'(o_drive[0]), 32'h00);
    step(1'b0, 3'd0, 3'd0);
    chk("single_e1_drive", 32'(o_drive[0]), 32'h08);
    chk("single_e1_load", 32'(o_load[0]), 32'h00);
    step(1'b0, 3'd0, 3'd0);
    chk("single_e2_drive", 32'(o_drive[0]), 32'h08);
    chk("single_e2_load", 32'(o_load[0]), 32'h20);
    chk("single_e2_done", 32'(o_done[0]), 32'd1);
    step(1'b0, 3'd0, 3'd0);
    chk("single_e3_drive", 32'(o_drive[0]), 32'h00);
    chk("single_e3_busy", 32'(o_busy[0]), 32'd1);
    step(1'b0, 3'd0, 3'd0);
    chk("single_e4_busy", 32'(o_busy[0]), 32'd0);
    repeat (6) step(1'b0, 3'd0, 3'd0);

    // held-valid burst 0->1, 2->3, 4->5
    done_a.delete();
    done_b.delete();
    saw_not_ready = 1'b0;
    k = 0;
    guard = 0;
    while (k < 3 && guard < 30) begin
      logic acc;
      acc = qsize(0) < 2;
      step(1'b1, 3'(2 * k), 3'(2 * k + 1));
      if (o_ready[0] === 1'b0) saw_not_ready = 1'b1;
      if (acc) k++;
      guard++;
    end
    chk("burst_accept_budget", 32'(k), 32'd3);
    chk("burst_ready_drop", 32'(saw_not_ready), 32'd1);
    repeat (12) step(1'b0, 3'd0, 3'd0);
    chk("burst_done_a_count", 32'(done_a.size()), 32'd3);
    if (done_a.size() == 3) begin
      chk("burst_done_a_gap0", 32'(done_a[1] - done_a[0]), 32'd3);
      chk("burst_done_a_gap1", 32'(done_a[2] - done_a[1]), 32'd3);
    end
    chk("burst_done_b_count", 32'(done_b.size()), 32'd3);
    if (done_b.size() == 3) begin
      chk("ta0_done_b_gap0", 32'(done_b[1] - done_b[0]), 32'd2);
      chk("ta0_done_b_gap1", 32'(done_b[2] - done_b[1]), 32'd2);
    end

    // invalid source 7 between two valid requests on the NUM_SRC=6 instance
    for (int i = 0; i < 3; i++) begin
      done_cnt[i] = 0;
      err_cnt[i]  = 0;
    end
    k = 0;
    guard = 0;
    while (k < 3 && guard < 30) begin
      logic acc;
      acc = qsize(2) < 2;
      case (k)
        0: step(1'b1, 3'd1, 3'd2);
        1: step(1'b1, 3'd7, 3'd3);
        default: step(1'b1, 3'd5, 3'd6);
      endcase
      if (acc) k++;
      guard++;
    end
    chk("invalid_accept_budget", 32'(k), 32'd3);
    repeat (16) step(1'b0, 3'd0, 3'd0);
    chk("invalid_err_c_once", 32'(err_cnt[2]), 32'd1);
    chk("invalid_done_c_two", 32'(done_cnt[2]), 32'd2);
    chk("invalid_no_err_a", 32'(err_cnt[0]), 32'd0);

    // asynchronous reset during LOAD with one entry still queued
    step(1'b1, 3'd1, 3'd2);
    step(1'b1, 3'd3, 3'd4);
    step(1'b0, 3'd0, 3'd0);
    chk("rst_pre_load_done", 32'(o_done[0]), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    req_valid = 1'b1;
    req_src   = 3'd2;
    req_dst   = 3'd2;
    @(posedge clk);
    @(negedge clk);
    check_all();
    for (int i = 0; i < 3; i++) done_cnt[i] = 0;
    req_valid = 1'b0;
    rst_n = 1'b1;
    repeat (8) step(1'b0, 3'd0, 3'd0);
    chk("rst_no_done_after", 32'(done_cnt[0]), 32'd0);
    chk("rst_busy_after", 32'(o_busy[0]), 32'd0);
    chk("rst_ready_after", 32'(o_ready[0]), 32'd1);

    // random traffic
    repeat (400)
      step($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    repeat (10) step(1'b0, 3'd0, 3'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
